// File: rtl/br_pkg.sv
// Shared types and constants for the conditional-branch controller:
// 2-bit predictor states, branch funct3 encodings and counter limits.
package br_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_ILL0 = 3'b010;
  localparam logic [2:0] F3_ILL1 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 != F3_ILL0) && (f3 != F3_ILL1);
  endfunction

  function automatic logic br_outcome(input logic [2:0] f3, input logic less, input logic equal);
    logic res;
    case (f3)
      F3_BEQ:           res = equal;
      F3_BNE:           res = ~equal;
      F3_BLT, F3_BLTU:  res = less;
      F3_BGE, F3_BGEU:  res = ~less;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

  // Saturating step of a 2-bit counter toward ST (taken) or SNT (not taken).
  function automatic bht_state_e bht_next(input bht_state_e s, input logic taken);
    bht_state_e n;
    case (s)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = WNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bht.sv
// Branch history table: array of 2-bit saturating counters with an
// asynchronous read port for fetch and a clocked update port for resolve.
module bht
  import br_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_state_e       rd_state,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bht_state_e tbl [ENTRIES];

  // Read sees the stored value only, so a same-cycle update is not bypassed.
  assign rd_state = tbl[rd_idx];

  // Table state: reset to weakly-not-taken, otherwise saturating update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= WNT;
      end
    end else if (upd_en) begin
      tbl[upd_idx] <= bht_next(tbl[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/br_ctrl.sv
// Conditional-branch controller: fetch-stage direction prediction, execute-stage
// resolution with redirect pulse, predictor training and statistics counters.
module br_ctrl
  import br_pkg::*;
#(
  parameter int BHT_ENTRIES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc_f,
  output logic        o_pred_taken_f,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_br_un,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic [15:0] o_br_cnt,
  output logic [15:0] o_mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  bht_state_e       fetch_state;
  logic             legal;
  logic             taken;
  logic             resolve;
  logic             mispred;
  logic             unused;

  assign fetch_idx      = i_pc_f[IDX_W+1:2];
  assign ex_idx         = i_ex_pc[IDX_W+1:2];
  assign o_pred_taken_f = fetch_state[1];
  assign o_br_un        = i_ex_funct3[1];
  assign unused         = ^{i_pc_f[31:IDX_W+2], i_pc_f[1:0]};

  // Resolve qualification; the slot right behind a redirect is wrong-path and squashed.
  always_comb begin
    legal   = f3_legal(i_ex_funct3);
    taken   = br_outcome(i_ex_funct3, i_br_less, i_br_equal);
    resolve = i_ex_valid & i_ex_is_br & legal & ~o_redirect_valid;
    mispred = resolve & (taken != i_ex_pred_taken);
  end

  bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .rd_idx    (fetch_idx),
    .rd_state  (fetch_state),
    .upd_en    (resolve),
    .upd_idx   (ex_idx),
    .upd_taken (taken)
  );

  // Redirect pulse, correct-path PC (held between pulses) and saturating statistics.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= 32'd0;
      o_br_cnt         <= 16'd0;
      o_mispred_cnt    <= 16'd0;
    end else begin
      o_redirect_valid <= mispred;
      if (mispred) begin
        o_redirect_pc <= taken ? i_ex_target : (i_ex_pc + 32'd4);
      end
      if (resolve && (o_br_cnt != CNT_SAT)) begin
        o_br_cnt <= o_br_cnt + 16'd1;
      end
      if (mispred && (o_mispred_cnt != CNT_SAT)) begin
        o_mispred_cnt <= o_mispred_cnt + 16'd1;
      end
    end
  end

endmodule
